fusion_accumulator: RTL and testbench

- Downstream consumer of the quarter-unit multiplier slice.
- Takes its 16-bit packed product word, unpacks it into 1, 2 or 4 lanes according to the precision mode, and extends each lane to ACC_W bits.
- Accumulates each lane over a group of beats, closed by in_last.
- Presents the per-lane partial sums to the next stage over a valid/ready handshake.

---
 rtl/fusion_accumulator.sv | 167 ++++++++++++++++
 tb/tb_fusion_accumulator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_accumulator.sv
// Unpacks 16-bit product words into 1/2/4 lanes and sums each lane over a group closed by in_last or MAX_BEATS.
// Result registered: out_valid the cycle after the closing beat; in_ready=0 while a result waits for out_ready.
module fusion_accumulator #(
  parameter int ACC_W     = 24,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  input  logic [1:0]           in_mode,
  input  logic                 in_signed,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*ACC_W-1:0]   out_acc,
  output logic [1:0]           out_mode,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_trunc,
  output logic                 out_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_t                    state_q, state_d;
  logic [3:0][ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [1:0]                mode_q, mode_d;
  logic                      signed_q, signed_d;
  logic                      trunc_q, trunc_d;
  logic                      err_q, err_d;

  logic                      accept;
  logic [1:0]                lane_mode;
  logic                      lane_signed;
  logic [3:0][ACC_W-1:0]     ext_lanes;
  logic [CNT_W-1:0]          count_inc;
  logic                      hit_max;

  // Reserved mode 3 yields all-zero lanes, so such a group sums to 0.
  function automatic logic [3:0][ACC_W-1:0] unpack_lanes(
    input logic [15:0] d,
    input logic [1:0]  m,
    input logic        s
  );
    logic [3:0][ACC_W-1:0] r;
    r = '0;
    case (m)
      2'd0: begin
        for (int k = 0; k < 4; k++) begin
          r[k] = {{(ACC_W-4){s & d[4*k+3]}}, d[4*k +: 4]};
        end
      end
      2'd1: begin
        for (int k = 0; k < 2; k++) begin
          r[k] = {{(ACC_W-8){s & d[8*k+7]}}, d[8*k +: 8]};
        end
      end
      2'd2: r[0] = {{(ACC_W-16){s & d[15]}}, d};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q != S_DRAIN);
  assign accept    = in_valid & in_ready;

  // The first beat of a group uses its own mode/sign; later beats use the latched ones.
  assign lane_mode   = (state_q == S_IDLE) ? in_mode   : mode_q;
  assign lane_signed = (state_q == S_IDLE) ? in_signed : signed_q;
  assign ext_lanes   = unpack_lanes(in_data, lane_mode, lane_signed);

  assign count_inc = count_q + CNT_W'(1);
  assign hit_max   = (count_inc == MAX_CNT);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    mode_d   = mode_q;
    signed_d = signed_q;
    trunc_d  = trunc_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d   = in_mode;
          signed_d = in_signed;
          acc_d    = ext_lanes;
          count_d  = count_inc;
          err_d    = (in_mode == 2'd3);
          if (in_last || hit_max) begin
            state_d = S_DRAIN;
            trunc_d = ~in_last;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end

      S_ACCUM: begin
        if (accept) begin
          for (int k = 0; k < 4; k++) begin
            acc_d[k] = acc_q[k] + ext_lanes[k];
          end
          count_d = count_inc;
          err_d   = err_q | (in_mode != mode_q) | (in_signed != signed_q);
          if (in_last || hit_max) begin
            state_d = S_DRAIN;
            trunc_d = ~in_last;
          end
        end
      end

      S_DRAIN: begin
        if (out_ready) begin
          state_d  = S_IDLE;
          acc_d    = '0;
          count_d  = '0;
          mode_d   = 2'd0;
          signed_d = 1'b0;
          trunc_d  = 1'b0;
          err_d    = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      mode_q   <= 2'd0;
      signed_q <= 1'b0;
      trunc_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      signed_q <= signed_d;
      trunc_q  <= trunc_d;
      err_q    <= err_d;
    end
  end

  assign out_valid = (state_q == S_DRAIN);
  assign out_acc   = acc_q;
  assign out_mode  = mode_q;
  assign out_count = count_q;
  assign out_trunc = trunc_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_fusion_accumulator.sv
// Bench for fusion_accumulator: directed groups plus random groups scored against a lane-arithmetic model.
module tb_fusion_accumulator;

  localparam int ACC_W = 24;
  localparam int MAXB  = 4;
  localparam int CNT_W = 9;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_data;
  logic [1:0]          in_mode;
  logic                in_signed;
  logic                in_last;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [4*ACC_W-1:0]  out_acc;
  logic [1:0]          out_mode;
  logic [CNT_W-1:0]    out_count;
  logic                out_trunc;
  logic                out_err;

  fusion_accumulator #(.ACC_W(ACC_W), .MAX_BEATS(MAXB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_mode(out_mode), .out_count(out_count), .out_trunc(out_trunc),
    .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4*ACC_W-1:0] acc;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   count;
    logic               trunc;
    logic               err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic rand_rdy = 1'b0;
  logic rdy_cmd  = 1'b1;

  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_cmd;
  end

  // Reference model state: the open group's latched attributes and exact lane sums.
  int          grp_n;
  logic [1:0]  grp_mode;
  logic        grp_sgn;
  logic        grp_err;
  longint      grp_sum[4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic longint lane_val(input logic [15:0] d, input logic [1:0] m, input logic s, input int k);
    int     w;
    longint raw;
    case (m)
      2'd0: w = 4;
      2'd1: w = 8;
      2'd2: w = 16;
      default: w = 0;
    endcase
    if (w == 0 || k >= 16 / w) return 0;
    raw = longint'(d >> (k * w)) & ((longint'(1) << w) - 1);
    if (s && raw >= (longint'(1) << (w - 1))) raw = raw - (longint'(1) << w);
    return raw;
  endfunction

  task automatic model_accept(input logic [15:0] d, input logic [1:0] m, input logic s, input logic l);
    exp_t e;
    if (grp_n == 0) begin
      grp_mode = m;
      grp_sgn  = s;
      grp_err  = (m == 2'd3);
      for (int k = 0; k < 4; k++) grp_sum[k] = 0;
    end else if (m != grp_mode || s != grp_sgn) begin
      grp_err = 1'b1;
    end
    for (int k = 0; k < 4; k++) grp_sum[k] += lane_val(d, grp_mode, grp_sgn, k);
    grp_n++;
    if (l || grp_n == MAXB) begin
      for (int k = 0; k < 4; k++) e.acc[k*ACC_W +: ACC_W] = ACC_W'(grp_sum[k]);
      e.mode  = grp_mode;
      e.count = CNT_W'(grp_n);
      e.trunc = ~l;
      e.err   = grp_err;
      sb_q.push_back(e);
      grp_n = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic [1:0] m, input logic s, input logic l);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    in_signed = s;
    in_last   = l;
    while (!in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("in_ready_wait", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(d, m, s, l);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result act=valid exp=none_pending");
      end else begin
        e = sb_q.pop_front();
        chk("sb_acc", out_acc, e.acc);
        chk("sb_mode", out_mode, e.mode);
        chk("sb_count", out_count, e.count);
        chk("sb_trunc", out_trunc, e.trunc);
        chk("sb_err", out_err, e.err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4*ACC_W-1:0] x;
    logic [15:0]        d;
    logic [1:0]         m, bm;
    logic               s, bs, l;
    int                 len, r, t;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_signed = 1'b0; in_last = 1'b0;
    grp_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_flags", {out_trunc, out_err}, 0);

    beat(16'hF21F, 2'd0, 1'b1, 1'b0);
    beat(16'hF21F, 2'd0, 1'b1, 1'b1);
    x = {ACC_W'(-2), ACC_W'(4), ACC_W'(2), ACC_W'(-2)};
    chk("m0s_valid", out_valid, 1);
    chk("m0s_acc", out_acc, x);
    chk("m0s_count", out_count, 2);
    chk("m0s_err", out_err, 0);
    idle(1);

    beat(16'h80FF, 2'd1, 1'b0, 1'b0);
    beat(16'h80FF, 2'd1, 1'b0, 1'b1);
    x = {ACC_W'(0), ACC_W'(0), ACC_W'(256), ACC_W'(510)};
    chk("m1u_acc", out_acc, x);
    idle(1);
    beat(16'h80FF, 2'd1, 1'b1, 1'b0);
    beat(16'h80FF, 2'd1, 1'b1, 1'b1);
    x = {ACC_W'(0), ACC_W'(0), ACC_W'(-256), ACC_W'(-2)};
    chk("m1s_acc", out_acc, x);
    idle(1);

    rdy_cmd = 1'b0;
    beat(16'hFF80, 2'd2, 1'b1, 1'b0);
    beat(16'hFF80, 2'd2, 1'b1, 1'b0);
    beat(16'hFF80, 2'd2, 1'b1, 1'b1);
    x = {ACC_W'(0), ACC_W'(0), ACC_W'(0), ACC_W'(-384)};
    chk("m2s_acc", out_acc, x);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_acc", out_acc, x);
    end
    rdy_cmd = 1'b1;
    idle(1);
    idle(1);
    chk("release_in_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);

    for (int i = 0; i < 4; i++) beat(16'h0001, 2'd2, 1'b0, 1'b0);
    x = {ACC_W'(0), ACC_W'(0), ACC_W'(0), ACC_W'(4)};
    chk("trunc_valid", out_valid, 1);
    chk("trunc_acc", out_acc, x);
    chk("trunc_count", out_count, 4);
    chk("trunc_flag", out_trunc, 1);
    idle(1);

    beat(16'h1234, 2'd0, 1'b0, 1'b0);
    beat(16'h1234, 2'd1, 1'b0, 1'b1);
    x = {ACC_W'(2), ACC_W'(4), ACC_W'(6), ACC_W'(8)};
    chk("mism_err", out_err, 1);
    chk("mism_acc", out_acc, x);
    chk("mism_mode", out_mode, 0);
    idle(1);
    beat(16'h0005, 2'd2, 1'b0, 1'b1);
    chk("after_mism_err", out_err, 0);
    chk("after_mism_trunc", out_trunc, 0);
    idle(1);

    beat(16'h0007, 2'd2, 1'b0, 1'b0);
    beat(16'h0007, 2'd2, 1'b0, 1'b0);
    beat(16'h0007, 2'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    grp_n = 0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_acc", out_acc, 0);
    chk("midrst_count", out_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    idle(3);
    chk("midrst_quiet", out_valid, 0);
    beat(16'h0003, 2'd2, 1'b0, 1'b1);
    x = {ACC_W'(0), ACC_W'(0), ACC_W'(0), ACC_W'(3)};
    chk("post_rst_acc", out_acc, x);
    chk("post_rst_count", out_count, 1);
    idle(1);

    rand_rdy = 1'b1;
    for (int g = 0; g < 150; g++) begin
      r   = $urandom_range(0, 9);
      m   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, MAXB);
      for (int b = 0; b < len; b++) begin
        d  = 16'($urandom);
        bm = m;
        bs = s;
        if ($urandom_range(0, 9) == 0) begin
          bm = 2'($urandom_range(0, 3));
          bs = 1'($urandom_range(0, 1));
        end
        l = (b == len - 1) && (len < MAXB || $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        beat(d, bm, bs, l);
      end
    end

    rand_rdy = 1'b0;
    rdy_cmd  = 1'b1;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      idle(1);
      t++;
    end
    idle(2);
    chk("sb_drained", sb_q.size(), 0);
    chk("end_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
